// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider: FSM state codes, handshake
// levels, reset level and bus widths, plus a conditional two's-complement helper.
package div_unit_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    // Active-low reset level.
    localparam logic RST_ENABLE = 1'b0;

    // Handshake levels.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Two's-complement negation when en=1, pass-through otherwise. Used both
    // to take operand magnitudes and to restore result signs.
    function automatic logic [REG_BUS-1:0] neg_if(input logic [REG_BUS-1:0] v,
                                                  input logic               en);
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift the partial remainder left,
// bring in the next dividend bit, and subtract the divisor if it fits.
module div_step
    import div_unit_pkg::*;
(
    input  logic [REG_BUS-1:0] i_rem,
    input  logic               i_bit,
    input  logic [REG_BUS-1:0] i_divisor,
    output logic [REG_BUS-1:0] o_rem,
    output logic               o_qbit
);

    // The incoming remainder is always below the divisor, so the shifted value
    // needs one extra bit but the kept remainder always fits back in 32 bits.
    logic [REG_BUS:0] w_shifted;

    assign w_shifted = {i_rem, i_bit};
    assign o_qbit    = (w_shifted >= {1'b0, i_divisor});
    // Modulo-2^32 subtraction is exact here because the true difference is
    // smaller than the divisor.
    assign o_rem     = o_qbit ? (w_shifted[REG_BUS-1:0] - i_divisor)
                              : w_shifted[REG_BUS-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32/32 divider (DIV/DIVU) with a start/ready handshake toward EX.
// result_o = {remainder, quotient}. One quotient bit per clock; operands are
// latched as magnitudes at acceptance and signs are restored on the last edge.
// Optional build macro: DIV_FAST_ZERO_EN -- a zero dividend skips the
// iterations and finishes through the divide-by-zero path.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_e                r_state,    w_state_nxt;
    logic [REG_BUS-1:0]        r_divisor,  w_divisor_nxt;
    // Holds the dividend magnitude; shifts left each iteration while quotient
    // bits enter at the bottom, so it ends up holding the quotient magnitude.
    logic [REG_BUS-1:0]        r_dividend, w_dividend_nxt;
    logic [REG_BUS-1:0]        r_rem,      w_rem_nxt;
    logic                      r_neg_quot, w_neg_quot_nxt;
    logic                      r_neg_rem,  w_neg_rem_nxt;
    logic [5:0]                r_cnt,      w_cnt_nxt;
    logic [DOUBLE_REG_BUS-1:0] r_result,   w_result_nxt;
    logic                      r_ready,    w_ready_nxt;

    logic [REG_BUS-1:0]        w_step_rem;
    logic                      w_step_qbit;
    logic                      w_zero_path;
    logic                      w_accept;

    div_step u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_dividend[REG_BUS-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

`ifdef DIV_FAST_ZERO_EN
    assign w_zero_path = (opdata2_i == '0) || (opdata1_i == '0);
`else
    assign w_zero_path = (opdata2_i == '0);
`endif

    // A flush arriving with the request wins: nothing is accepted.
    assign w_accept = (start_i == DIV_START) && !annul_i;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        // NOTE: every target gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        w_state_nxt    = r_state;
        w_divisor_nxt  = r_divisor;
        w_dividend_nxt = r_dividend;
        w_rem_nxt      = r_rem;
        w_neg_quot_nxt = r_neg_quot;
        w_neg_rem_nxt  = r_neg_rem;
        w_cnt_nxt      = r_cnt;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;

        case (r_state)
            DIV_FREE: begin
                w_ready_nxt  = DIV_RESULT_NOT_READY;
                w_result_nxt = '0;
                if (w_accept) begin
                    w_divisor_nxt  = neg_if(opdata2_i, signed_div_i && opdata2_i[REG_BUS-1]);
                    w_dividend_nxt = neg_if(opdata1_i, signed_div_i && opdata1_i[REG_BUS-1]);
                    w_neg_quot_nxt = signed_div_i && (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
                    w_neg_rem_nxt  = signed_div_i && opdata1_i[REG_BUS-1];
                    w_rem_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = w_zero_path ? DIV_BY_ZERO : DIV_ON;
                end
            end

            DIV_BY_ZERO: begin
                w_result_nxt = '0;
                if (annul_i) begin
                    w_ready_nxt = DIV_RESULT_NOT_READY;
                    w_state_nxt = DIV_FREE;
                end else begin
                    w_ready_nxt = DIV_RESULT_READY;
                    w_state_nxt = DIV_END;
                end
            end

            DIV_ON: begin
                if (annul_i) begin
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_result_nxt = '0;
                    w_state_nxt  = DIV_FREE;
                end else if (r_cnt != 6'd32) begin
                    w_rem_nxt      = w_step_rem;
                    w_dividend_nxt = {r_dividend[REG_BUS-2:0], w_step_qbit};
                    w_cnt_nxt      = r_cnt + 6'd1;
                end else begin
                    w_result_nxt = {neg_if(r_rem, r_neg_rem), neg_if(r_dividend, r_neg_quot)};
                    w_ready_nxt  = DIV_RESULT_READY;
                    w_state_nxt  = DIV_END;
                end
            end

            DIV_END: begin
                // Result is held for EX until it drops the request.
                if (start_i == DIV_STOP) begin
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_result_nxt = '0;
                    w_state_nxt  = DIV_FREE;
                end
            end

            default: begin
                w_ready_nxt  = DIV_RESULT_NOT_READY;
                w_result_nxt = '0;
                w_state_nxt  = DIV_FREE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so evaluation order inside the block is irrelevant.
        if (rst == RST_ENABLE) begin
            // NOTE: the datapath registers are reset too (not just the FSM),
            // so a mid-divide reset leaves no stale operands or count behind.
            r_state    <= DIV_FREE;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_ready    <= DIV_RESULT_NOT_READY;
        end else begin
            r_state    <= w_state_nxt;
            r_divisor  <= w_divisor_nxt;
            r_dividend <= w_dividend_nxt;
            r_rem      <= w_rem_nxt;
            r_neg_quot <= w_neg_quot_nxt;
            r_neg_rem  <= w_neg_rem_nxt;
            r_cnt      <= w_cnt_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit. Latency is counted in rising
// edges after the edge that accepts start_i: 33 for the iterative path,
// 1 for the divide-by-zero path. Honours DIV_FAST_ZERO_EN like the RTL.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_pass   = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Drive a request on a falling edge and wait through the accepting edge.
    task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
    endtask

    // Count edges until ready_o rises; a missing ready returns lat = 99.
    task automatic wait_ready(output int lat, output logic [63:0] res);
        lat = 99;
        res = 'x;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = i;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res);
        start_div(s, a, b);
        wait_ready(lat, res);
    endtask

    // Drop start and confirm the divider returns to idle on the next edge.
    task automatic release_start(input string name);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("FAIL %s_release: ready=%b result=%h, required ready=0 result=0",
                     name, ready_o, result_o);
        else n_pass++;
    endtask

    // Run one divide and compare latency and result against hand values.
    task automatic div_case(input string name, input logic s, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int          lat;
        logic [63:0] res;
        run_div(s, a, b, lat, res);
        n_checks++;
        if (lat !== exp_lat)
            $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (res !== exp_res)
            $display("FAIL %s_result: got %h, required %h", name, res, exp_res);
        else n_pass++;
        release_start(name);
    endtask

    task automatic test_reset();
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("FAIL reset: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu_basic();
        int          lat;
        logic [63:0] res;
        // Before the accepting edge ready_o must still be low.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b0) $display("FAIL ready_with_start: ready=%b, required 0", ready_o);
        else n_pass++;
        @(posedge clk);
        wait_ready(lat, res);
        n_checks++;
        if (lat !== 33) $display("FAIL divu_latency: got %0d edges, required 33", lat);
        else n_pass++;
        n_checks++;
        if (res !== {32'd2, 32'd14}) $display("FAIL divu_result: got %h, required %h", res, {32'd2, 32'd14});
        else n_pass++;
        // Held while start stays high; annul is ignored in the finished state.
        @(negedge clk);
        annul_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14})
            $display("FAIL divu_hold: ready=%b result=%h, required ready=1 result=%h",
                     ready_o, result_o, {32'd2, 32'd14});
        else n_pass++;
        @(negedge clk);
        annul_i = 1'b0;
        release_start("divu");
    endtask

    task automatic test_div_signed();
        div_case("div_neg_pos", 1'b1, 32'hFFFF_FF9C, 32'd7,        33, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        div_case("div_pos_neg", 1'b1, 32'd100,       32'hFFFF_FFF9, 33, {32'd2,         32'hFFFF_FFF2});
        div_case("div_neg_neg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'd14});
    endtask

    task automatic test_boundaries();
        div_case("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});
        div_case("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         33, {32'd0, 32'hFFFF_FFFF});
        div_case("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'd0});
    endtask

    task automatic test_div_by_zero();
        div_case("divu_by_zero", 1'b0, 32'd1234,      32'd0, 1, 64'd0);
        div_case("div_by_zero",  1'b1, 32'h8000_0000, 32'd0, 1, 64'd0);
    endtask

    task automatic test_zero_dividend();
`ifdef DIV_FAST_ZERO_EN
        div_case("zero_dividend", 1'b0, 32'd0, 32'd5, 1, 64'd0);
`else
        div_case("zero_dividend", 1'b0, 32'd0, 32'd5, 33, 64'd0);
`endif
    endtask

    task automatic test_annul();
        int          lat;
        logic [63:0] res;
        logic        saw_ready;
        start_div(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("FAIL annul_next: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        else n_pass++;
        // Keep annul asserted with a fresh request: it must not be accepted.
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        saw_ready = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) saw_ready = 1'b1;
        end
        n_checks++;
        if (saw_ready !== 1'b0) $display("FAIL annul_blocks_start: ready rose=%b, required 0", saw_ready);
        else n_pass++;
        // Dropping annul lets the pending request through with full latency.
        @(negedge clk);
        annul_i = 1'b0;
        @(posedge clk);
        wait_ready(lat, res);
        n_checks++;
        if (lat !== 33 || res !== {32'd0, 32'd10})
            $display("FAIL after_annul: lat=%0d result=%h, required lat=33 result=%h", lat, res, {32'd0, 32'd10});
        else n_pass++;
        release_start("after_annul");
    endtask

    task automatic test_reset_mid();
        start_div(1'b0, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0)
            $display("FAIL reset_mid: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        div_case("after_reset", 1'b0, 32'd1000, 32'd3, 33, {32'd1, 32'd333});
    endtask

    task automatic test_operand_change();
        int          lat;
        logic [63:0] res;
        start_div(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        opdata1_i = 32'd999; opdata2_i = 32'd0; signed_div_i = 1'b1;
        wait_ready(lat, res);
        n_checks++;
        if (lat !== 28 || res !== {32'd2, 32'd14})
            $display("FAIL operand_change: lat=%0d result=%h, required lat=28 result=%h", lat, res, {32'd2, 32'd14});
        else n_pass++;
        release_start("operand_change");
    endtask

    task automatic test_back_to_back();
        div_case("b2b_first",  1'b0, 32'd12345678,  32'd1000, 33, {32'd678, 32'd12345});
        div_case("b2b_second", 1'b1, 32'hFFFF_FFF9, 32'd2,    33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_boundaries();
        test_div_by_zero();
        test_zero_dividend();
        test_annul();
        test_reset_mid();
        test_operand_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
